// File: rtl/fpdiv_arbiter_pkg.sv
// Shared definitions for the two-requester FP divider front end:
// FSM encoding, operand width and the divider/watchdog timing constants.
package fpdiv_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DATA_W     = 32;
    localparam int DIV_CYCLES = 26;
    localparam int WDOG_LIMIT = 32;
    localparam int WDOG_W     = 6;

endpackage

// File: rtl/fpdiv_arbiter_rr_arb2.sv
// Two-way round-robin grant: a 1-bit pointer breaks ties, the mask removes
// a requester from consideration, and the pointer flips away from each winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic       ptr;
    logic [1:0] elig;

    always_comb begin
        elig = req & ~mask;
        gnt  = 2'b00;
        if (en) begin
            if (elig == 2'b11)
                gnt = ptr ? 2'b10 : 2'b01;
            else
                gnt = elig;
        end
    end

    // Winner 0 hands priority to 1 and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (gnt != 2'b00)
            ptr <= gnt[0];
    end

endmodule

// File: rtl/fpdiv_arbiter.sv
// Arbitrates two requesters onto one external FP divider, latches operands,
// captures the result and aborts via watchdog if the divider never finishes.
module fpdiv_arbiter
    import fpdiv_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] y0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] y1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] z,
    output logic              err,
    output logic              busy,
    output logic              div_run,
    output logic [DATA_W-1:0] div_x,
    output logic [DATA_W-1:0] div_y,
    input  logic              div_stall,
    input  logic [DATA_W-1:0] div_z
);

    state_t            state, next_state;
    logic [1:0]        gnt;
    logic [1:0]        mask;
    logic              owner;
    logic              abort;
    logic              just_done;
    logic [WDOG_W-1:0] wdog;
    logic              wdog_hit;

    // The requester just served sits out the first IDLE cycle, while it drops req.
    assign mask     = just_done ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign wdog_hit = (wdog == WDOG_W'(WDOG_LIMIT - 1));

    rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_IDLE),
        .req  ({req1, req0}),
        .mask (mask),
        .gnt  (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (gnt != 2'b00) next_state = ST_RUN;
            ST_RUN:  if (!div_stall || wdog_hit) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        div_run = (state == ST_RUN);
        busy    = (state != ST_IDLE);
        ack0    = (state == ST_DONE) && !owner;
        ack1    = (state == ST_DONE) && owner;
        err     = (state == ST_DONE) && abort;
    end

    // Operand latch on grant, watchdog count and result capture at end of RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_x     <= '0;
            div_y     <= '0;
            z         <= '0;
            owner     <= 1'b0;
            abort     <= 1'b0;
            wdog      <= '0;
            just_done <= 1'b0;
        end else begin
            just_done <= (state == ST_DONE);
            if (state == ST_IDLE && gnt != 2'b00) begin
                owner <= gnt[1];
                div_x <= gnt[1] ? x1 : x0;
                div_y <= gnt[1] ? y1 : y0;
                wdog  <= '0;
            end else if (state == ST_RUN) begin
                wdog <= wdog + WDOG_W'(1);
                if (!div_stall) begin
                    z     <= div_z;
                    abort <= 1'b0;
                end else if (wdog_hit) begin
                    z     <= '0;
                    abort <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Bench for fpdiv_arbiter: stub divider beside the DUT, timeline reference
// model checked every cycle, directed vector table plus random traffic.
module tb_fpdiv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] x0, y0, x1, y1;
    logic        ack0, ack1, err, busy, div_run, div_stall;
    logic [31:0] z, div_x, div_y, div_z;
    logic        stall_force;
    logic [5:0]  dcnt;

    int n_cmp, n_fail, cyc;

    fpdiv_arbiter dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .ack0(ack0), .ack1(ack1), .z(z), .err(err), .busy(busy),
        .div_run(div_run), .div_x(div_x), .div_y(div_y),
        .div_stall(div_stall), .div_z(div_z)
    );

    always #5 clk = ~clk;

    // Stub divider: stalls for 26 run cycles, known results for the directed operands.
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (b[30:0] == 31'd0) return {a[31] ^ b[31], 8'hFF, 23'd0};
        return (a ^ {b[15:0], b[31:16]}) + 32'h9E3779B9;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) dcnt <= 6'd0;
        else     dcnt <= div_run ? dcnt + 6'd1 : 6'd0;
    end
    assign div_stall = stall_force | (div_run && dcnt < 6'd26);
    assign div_z     = fdiv(div_x, div_y);

    // Reference model: time since grant against the operation's total latency.
    bit          m_busy;
    int          m_t, m_lat, m_owner, m_ptr, m_block;
    bit          m_err;
    logic [31:0] m_x, m_y, m_zres, m_zreg;

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_lat = 28; m_owner = 0; m_ptr = 0; m_block = -1;
        m_err = 0; m_x = 0; m_y = 0; m_zres = 0; m_zreg = 0;
    endtask

    task automatic model_edge();
        int w;
        bit e0, e1;
        if (m_busy) begin
            m_t++;
            if (m_t == m_lat) m_zreg = m_zres;
            if (m_t == m_lat + 1) begin
                m_busy  = 0;
                m_block = m_owner;
            end
        end else begin
            w  = -1;
            e0 = req0 && m_block != 0;
            e1 = req1 && m_block != 1;
            if (e0 && e1) w = m_ptr;
            else if (e0)  w = 0;
            else if (e1)  w = 1;
            m_block = -1;
            if (w >= 0) begin
                m_busy  = 1;
                m_t     = 1;
                m_owner = w;
                m_ptr   = 1 - w;
                m_x     = (w == 1) ? x1 : x0;
                m_y     = (w == 1) ? y1 : y0;
                m_err   = stall_force;
                m_lat   = stall_force ? 33 : 28;
                m_zres  = stall_force ? 32'd0 : fdiv(m_x, m_y);
            end
        end
    endtask

    function automatic bit m_ack(input int i);
        return m_busy && m_t == m_lat && m_owner == i;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        bit run, done;
        run  = m_busy && m_t < m_lat;
        done = m_busy && m_t == m_lat;
        chk1("busy", busy, m_busy);
        chk1("div_run", div_run, run);
        chk1("ack0", ack0, m_ack(0));
        chk1("ack1", ack1, m_ack(1));
        chk1("err", err, done && m_err);
        chk1("ack_excl", ack0 & ack1, 1'b0);
        chk32("z", z, m_zreg);
        if (run) begin
            chk32("div_x", div_x, m_x);
            chk32("div_y", div_y, m_y);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic check_reset_outputs();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_div_run", div_run, 1'b0);
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_ack1", ack1, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_z", z, 32'd0);
        chk32("rst_div_x", div_x, 32'd0);
        chk32("rst_div_y", div_y, 32'd0);
    endtask

    // Asserted between edges: outputs must drop without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0; req0 = 0; req1 = 0; stall_force = 0;
        model_reset();
    endtask

    task automatic run_op(input int who, input logic [31:0] xa, input logic [31:0] ya,
                          input bit stall, input logic [31:0] ez, input bit eerr, input int elat);
        int got;
        got = -1;
        stall_force = stall;
        if (who == 0) begin req0 = 1; x0 = xa; y0 = ya; end
        else          begin req1 = 1; x1 = xa; y1 = ya; end
        for (int k = 1; k <= 60; k++) begin
            step();
            if ((who == 0 && ack0) || (who == 1 && ack1)) begin
                got = k;
                chk32("op_z", z, ez);
                chk1("op_err", err, eerr);
                break;
            end
        end
        chk32("op_latency", got, elat);
        if (who == 0) req0 = 0; else req1 = 0;
        stall_force = 0;
        step();
        step();
    endtask

    typedef struct {
        int          who;
        logic [31:0] x, y;
        bit          stall;
        logic [31:0] ez;
        bit          eerr;
        int          elat;
    } vec_t;

    vec_t tbl[4];
    int   order[6];
    int   n_ack, t0, t1;

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        rst = 1; req0 = 0; req1 = 0; stall_force = 0;
        x0 = 0; y0 = 0; x1 = 0; y1 = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 0;

        tbl[0] = '{0, 32'h40C00000, 32'h40000000, 0, 32'h40400000, 0, 28};
        tbl[1] = '{1, 32'h3F800000, 32'h00000000, 0, 32'h7F800000, 0, 28};
        tbl[2] = '{0, 32'h12345678, 32'h9ABCDEF0, 1, 32'h00000000, 1, 33};
        tbl[3] = '{1, 32'h40C00000, 32'h40000000, 0, 32'h40400000, 0, 28};
        for (int i = 0; i < 4; i++)
            run_op(tbl[i].who, tbl[i].x, tbl[i].y, tbl[i].stall, tbl[i].ez, tbl[i].eerr, tbl[i].elat);

        // Requester drops req while its operation is running.
        req1 = 1; x1 = 32'h40C00000; y1 = 32'h40000000;
        t1 = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 5) req1 = 0;
            if (ack1) begin t1 = k; break; end
        end
        chk32("drop_latency", t1, 28);
        step(); step();

        // Simultaneous requests straight after reset.
        do_reset();
        req0 = 1; x0 = 32'h40C00000; y0 = 32'h40000000;
        req1 = 1; x1 = 32'h3F800000; y1 = 32'h00000000;
        t0 = -1; t1 = -1;
        for (int k = 1; k <= 80; k++) begin
            step();
            if (ack0 && t0 < 0) begin t0 = k; req0 = 0; end
            if (ack1) begin t1 = k; req1 = 0; break; end
        end
        chk32("simul_ack0", t0, 28);
        chk32("simul_ack1", t1, 57);
        step(); step();

        // Fairness with both requests held continuously.
        do_reset();
        req0 = 1; req1 = 1;
        n_ack = 0;
        for (int k = 0; k < 220 && n_ack < 6; k++) begin
            step();
            if (ack0) begin order[n_ack] = 0; n_ack++; end
            else if (ack1) begin order[n_ack] = 1; n_ack++; end
        end
        req0 = 0; req1 = 0;
        chk32("fair_count", n_ack, 6);
        for (int i = 0; i < n_ack; i++)
            chk32("fair_order", order[i], i % 2);
        for (int i = 0; i < 35; i++) step();

        // Reset in the middle of RUN, then a normal operation.
        req0 = 1; x0 = 32'hDEADBEEF; y0 = 32'h3F000000;
        for (int i = 0; i < 10; i++) step();
        chk1("mid_run_active", div_run, 1'b1);
        do_reset();
        step();
        run_op(0, 32'h40C00000, 32'h40000000, 0, 32'h40400000, 0, 28);

        // Random traffic obeying the requester protocol.
        for (int c = 0; c < 1500; c++) begin
            step();
            if (m_ack(0)) req0 = 0;
            else if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1; x0 = $urandom; y0 = $urandom;
            end
            if (m_ack(1)) req1 = 0;
            else if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; x1 = $urandom; y1 = $urandom;
            end
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 35; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fpdiv_arbiter.md
FPDIV_ARBITER -- requirements
Module: fpdiv_arbiter

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0, req1  input  1 each  level request from requester 0 / 1.
REQ-005 x0, y0, x1, y1  input  32 each  dividend / divisor operands for requester 0 / 1.
REQ-006 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-007 z  output  32  result register, shared; valid while ack0 or ack1 is high.
REQ-008 err  output  1  one-cycle pulse, coincident with ack, on watchdog abort.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 div_run  output  1  run to divider; div_x, div_y  output  32 each  latched operands.
REQ-011 div_stall  input  1  divider stall; div_z  input  32  divider result.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE; reset state SHALL be IDLE.
REQ-013 IDLE: if any eligible req is high at a clock edge, grant one requester, latch its x/y into div_x/div_y, then go to RUN.
REQ-014 Arbitration SHALL be round-robin with a 1-bit pointer (reset 0): both requesting -> pointer's requester wins; after each grant, the pointer goes to the other requester.
REQ-015 RUN: div_run SHALL be high; div_x/div_y SHALL be held constant; requester inputs SHALL be ignored.
REQ-016 In RUN, an edge with div_stall low SHALL capture div_z into z and move to DONE.
REQ-017 DONE lasts exactly one cycle: div_run low (this clears the divider step counter), ack of the granted requester high, then go to IDLE.
REQ-018 Latency: grant at edge E0 -> div_run high in cycles 1..27 -> ack in cycle 28 -> IDLE in cycle 29. The earliest next grant SHALL be at the end of cycle 29.
REQ-019 Requesters hold req until ack and drop it in the cycle after ack. The just-served requester SHALL NOT be eligible in the first IDLE cycle after its DONE.
REQ-020 Watchdog: a 6-bit counter SHALL be cleared on grant and incremented each RUN cycle. If it reaches 32 with div_stall still high, go to DONE with z = 0 and err = 1 alongside ack.
REQ-021 ack0, ack1 and err SHALL never be high outside DONE; ack0 and ack1 SHALL never be high together.
REQ-022 z SHALL hold its last value until the next capture; reset value of z is 0.
REQ-023 A req that drops while its request is in RUN SHALL NOT abort the operation; the ack is still issued.

Reset
REQ-024 rst SHALL force IDLE immediately (asynchronously), including mid-RUN and during DONE.
REQ-025 Reset values: div_run 0, ack0/ack1 0, err 0, busy 0, z 0, div_x/div_y 0, pointer 0, watchdog 0.
REQ-026 After reset is released, the first request SHALL see full 28-cycle latency; the divider counter is already cleared because div_run was low.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, DIV_CYCLES = 26 and WDOG_LIMIT = 32.
REQ-028 The block SHALL NOT instantiate the divider; the divider is connected beside it at the parent level.
REQ-029 One sub-module is natural: rr_arb2, a 2-way round-robin grant with pointer and eligibility mask. All other logic stays inline.

Verification
REQ-030 Single request: req0, x0=0x40C00000, y0=0x40000000 -> ack0 in cycle 28 after grant, z=0x40400000, err=0.
REQ-031 Simultaneous requests after reset: req0 and req1 high together -> requester 0 served first; requester 1 granted at the end of cycle 29; ack1 arrives 28 cycles later.
REQ-032 Divide by zero: x1=0x3F800000, y1=0x00000000 -> ack1 with z=0x7F800000.
REQ-033 Watchdog: div_stall held high by the bench -> ack plus err in cycle 33 after grant, z=0, FSM returns to IDLE.
REQ-034 Reset mid-RUN: rst asserted at cycle 10 of RUN -> div_run, busy and acks low at once; after release, a new req0 completes with normal latency.
REQ-035 Fairness: req0 and req1 held continuously for 6 operations -> acks strictly alternate 0,1,0,1,0,1, with no ack overlap.
